// File: rtl/mips_pkg.sv
// Shared fetch-unit types and constants for the MIPS front end.
// FSM state encoding, instruction width and sequential PC step.
package mips_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } fetch_state_e;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Instruction queue: sync FIFO with flush and a registered head,
// so the head holds its last value while the queue is empty.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic [WIDTH-1:0] r_head;

  logic             w_pop;
  logic [AW-1:0]    w_rd_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_pop     = i_pop & r_valid;
  assign w_rd_nxt  = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign w_cnt_nxt = r_count + CW'(i_push) - CW'(w_pop);

  // Next head is the entry being written when it lands at the new read slot.
  assign w_head_nxt =
    (i_push && (w_rd_nxt == r_wr_ptr)) ? i_data : r_mem[w_rd_nxt];

  always_ff @(posedge clk) begin
    if (i_push && !i_flush)
      r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (i_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      r_valid  <= (w_cnt_nxt != '0);
      if (w_cnt_nxt != '0)
        r_head <= w_head_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/ifetch_prefetch.sv
// MIPS instruction prefetcher: one outstanding fetch, credit-gated queue.
// Optional IFQ_BYPASS_EN forwards a response straight out when empty.
module ifetch_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  import mips_pkg::*;

  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam int          QW       = 2 * INSTR_W;
  localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

  fetch_state_e r_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_issued_pc;

  logic [CW-1:0] w_count;
  logic          w_q_valid;
  logic [QW-1:0] w_q_head;
  logic          w_in_wait;
  logic          w_credit;
  logic          w_resp;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;

  assign w_in_wait = (r_state == S_WAIT);
  assign w_credit  =
    ({1'b0, w_count} + {{CW{1'b0}}, w_in_wait}) < LP_DEPTH;
  assign w_resp    = w_in_wait & mem_rvalid & ~redirect_valid;

`ifdef IFQ_BYPASS_EN
  assign w_bypass  = w_resp & ~w_q_valid;
`else
  assign w_bypass  = 1'b0;
`endif

  assign w_push = w_resp & ~(w_bypass & out_ready);
  assign w_pop  = out_ready & ~redirect_valid;

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (QW)
  ) u_ifq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({mem_rdata, r_issued_pc}),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_valid (w_q_valid),
    .o_head  (w_q_head),
    .o_count (w_count)
  );

  // A redirect outranks gnt/rvalid; an in-flight fetch must be drained.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_issued_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= word_align(redirect_pc);
      unique case (r_state)
        S_REQ:         r_state <= mem_gnt ? S_DROP : S_REQ;
        S_WAIT, S_DROP: r_state <= mem_rvalid ? S_IDLE : S_DROP;
        default:       r_state <= S_IDLE;
      endcase
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_credit)
            r_state <= S_REQ;
        end
        S_REQ: begin
          if (mem_gnt) begin
            r_issued_pc <= r_fetch_pc;
            r_fetch_pc  <= r_fetch_pc + PC_INC;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT, S_DROP: begin
          if (mem_rvalid)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = (r_state == S_REQ);
  assign mem_addr  = r_fetch_pc;
  assign out_valid = w_q_valid | w_bypass;
  assign out_instr = w_bypass ? mem_rdata : w_q_head[QW-1:INSTR_W];
  assign out_pc    = w_bypass ? r_issued_pc : w_q_head[INSTR_W-1:0];

endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
- Instruction fetch front end for the MIPS core.
- Sits between a variable-latency instruction memory port and the decode/register-file stage.
- Generates sequential fetch addresses and buffers returned instructions, each with its PC, in a small FIFO.
- Presents instructions downstream over a valid/ready handshake; a redirect from branch/jump resolution flushes the queue and any in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- redirect_valid  input  1  branch/jump taken; load redirect_pc.
- redirect_pc  input  32  new fetch target; bits [1:0] ignored (forced 0).
- mem_req  output  1  fetch request; held until mem_gnt.
- mem_addr  output  32  word-aligned fetch address.
- mem_gnt  input  1  request accepted this cycle.
- mem_rvalid  input  1  read data valid (>= 1 cycle after gnt).
- mem_rdata  input  32  fetched instruction.
- out_valid  output  1  queue head valid.
- out_instr  output  32  queue head instruction.
- out_pc  output  32  PC of queue head.
- out_ready  input  1  downstream consumes head when out_valid & out_ready.

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC, state S_IDLE, count=0, pointers=0, mem_req=0, mem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
- At most one outstanding fetch.
- Credit rule: a new request is issued only when count + (state==S_WAIT) < DEPTH.
- mem_addr always equals fetch_pc.
- FSM states:
  - S_IDLE: mem_req=0. If credit available and no redirect, go to S_REQ next cycle.
  - S_REQ: mem_req=1. On mem_gnt, fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0) and go to S_WAIT.
  - S_WAIT: mem_req=0. On mem_rvalid, push {mem_rdata, issued pc} and go to S_IDLE. Issued pc is kept in a register captured at gnt.
  - S_DROP: mem_req=0. On mem_rvalid, discard data and go to S_IDLE.
- Redirect has priority over every other event in the same cycle:
  - Queue flushed: count=0, rd_ptr=wr_ptr; out_valid=0 next cycle. A simultaneous pop is ignored.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - S_REQ with gnt in the same cycle -> S_DROP; fetch_pc still loads redirect_pc, not +4.
  - S_REQ without gnt -> stays S_REQ; mem_addr retargets next cycle. Memory samples only on gnt.
  - S_WAIT without rvalid -> S_DROP.
  - S_WAIT with rvalid in the same cycle -> data discarded, go to S_IDLE.
  - S_DROP -> stays S_DROP, or goes to S_IDLE if rvalid arrives the same cycle.
- Latency: rvalid at edge N -> out_valid at N+1 (registered queue).
- Minimum fetch loop: 3 cycles per instruction with single-cycle gnt and rvalid: IDLE -> REQ -> WAIT.
- Queue:
  - Push and pop in the same cycle are both allowed at any count, including full.
  - Push is never attempted when full (guaranteed by the credit rule).
  - Pop with out_valid=0 has no effect.
  - out_instr/out_pc hold their last value when empty.
- mem_rvalid outside S_WAIT/S_DROP is a protocol error and is ignored.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined: when the queue is empty, state is S_WAIT, no redirect and mem_rvalid=1:
  - out_valid, out_instr and out_pc are driven combinationally from mem_rdata and the issued pc in the same cycle.
  - If out_ready=1, the entry is consumed without a push. Otherwise it is pushed normally.
- Not defined: the response is always written to the queue; 1-cycle latency as above.

Decomposition:
- Shared package mips_pkg:
  - FSM state enum (S_IDLE, S_REQ, S_WAIT, S_DROP).
  - Constant INSTR_W=32.
  - Constant PC_INC=4.
- Sub-module ifq_fifo (synchronous FIFO with DEPTH/width parameters, push/pop/flush, count output). The FSM and address logic stay in ifetch_prefetch.

Test Plan:
- Reset, RESET_PC=0x100, memory with gnt same cycle and rvalid 1 cycle later, out_ready=1 -> out_pc sequence 0x100, 0x104, 0x108; reset values checked mid-run after an async rst pulse.
- out_ready=0, DEPTH=4 -> exactly 4 instructions buffered, mem_req stays 0, no 5th gnt. Then 1-cycle out_ready -> one pop and one new request issued.
- Redirect to 0x2000 in S_WAIT, rvalid 3 cycles later -> stale data dropped, out_valid=0, next out_pc=0x2000.
- Redirect to 0x3003 coinciding with mem_gnt -> S_DROP, next mem_addr=0x3000, stale response discarded.
- fetch_pc=0xFFFF_FFFC -> next mem_addr=0x0000_0000.
- IFQ_BYPASS_EN defined, empty queue, rvalid with out_ready=1 -> out_valid in the same cycle, count remains 0. Undefined build -> out_valid appears one cycle later.
